// File: rtl/cam_ctrl.sv
// Command sequencer for a CAM array: owns the entry valid bitmap and occupancy,
// serialises lookup/insert/delete/flush and returns hit/index/error.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SEARCH | key_q on cam_key, masked match vector captured
// EXEC   | priority encode, bitmap/occupancy update, optional CAM write
// RESP   | response held until consumer takes it
module cam_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDXW-1:0]  rsp_idx,
  output logic             rsp_err,
  output logic [WIDTH-1:0] cam_key,
  input  logic [DEPTH-1:0] cam_match,
  output logic             cam_wr_en,
  output logic [IDXW-1:0]  cam_wr_addr,
  output logic [WIDTH-1:0] cam_wr_data,
  output logic [IDXW:0]    occupancy,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {IDLE, SEARCH, EXEC, RESP} state_t;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;
  localparam logic [IDXW:0] OCC_ONE = {{IDXW{1'b0}}, 1'b1};
  localparam logic [IDXW:0] OCC_MAX = (IDXW+1)'(DEPTH);

  state_t state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] key_q;
  logic [DEPTH-1:0] hit_vec, valid;
  logic [IDXW:0]    occ_q;
  logic             any_hit;
  logic [IDXW-1:0]  hit_idx, free_idx;
  logic             do_write, do_delete, do_flush;
  logic             exec_hit, exec_err;
  logic [IDXW-1:0]  exec_idx;

  assign occupancy = occ_q;
  assign full      = (occ_q == OCC_MAX);
  assign empty     = (occ_q == '0);
  assign cam_key   = key_q;

  // Descending scan so the lowest set / lowest clear index is the last one written.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDXW'(i);
      if (!valid[i])  free_idx = IDXW'(i);
    end
    any_hit = |hit_vec;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    do_write  = 1'b0;
    do_delete = 1'b0;
    do_flush  = 1'b0;
    exec_hit  = 1'b0;
    exec_idx  = '0;
    exec_err  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SEARCH;
      end
      SEARCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = RESP;
        case (op_q)
          OP_LOOKUP: begin
            exec_hit = any_hit;
            exec_idx = any_hit ? hit_idx : '0;
          end
          OP_INSERT: begin
            if (any_hit) begin
              exec_hit = 1'b1;
              exec_idx = hit_idx;
            end else if (full) begin
              exec_err = 1'b1;
            end else begin
              do_write = 1'b1;
              exec_idx = free_idx;
            end
          end
          OP_DELETE: begin
            if (any_hit) begin
              exec_hit  = 1'b1;
              exec_idx  = hit_idx;
              do_delete = 1'b1;
            end else begin
              exec_err = 1'b1;
            end
          end
          default: do_flush = 1'b1;
        endcase
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
    endcase
  end

  // Write strobe is combinational from EXEC so an async reset kills it immediately.
  assign cam_wr_en   = do_write;
  assign cam_wr_addr = do_write ? free_idx : '0;
  assign cam_wr_data = do_write ? key_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_LOOKUP;
      key_q   <= '0;
      hit_vec <= '0;
      valid   <= '0;
      occ_q   <= '0;
      rsp_hit <= 1'b0;
      rsp_idx <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        key_q <= cmd_key;
      end
      if (state == SEARCH) hit_vec <= cam_match & valid;
      if (state == EXEC) begin
        rsp_hit <= exec_hit;
        rsp_idx <= exec_idx;
        rsp_err <= exec_err;
      end
      if (do_write) begin
        valid[free_idx] <= 1'b1;
        occ_q           <= occ_q + OCC_ONE;
      end else if (do_delete) begin
        valid[hit_idx] <= 1'b0;
        occ_q          <= occ_q - OCC_ONE;
      end else if (do_flush) begin
        valid <= '0;
        occ_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM array, directed command vectors and a
// response scoreboard drained by an independent monitor.
module tb_cam_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_key = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_hit;
  logic [IDXW-1:0]  rsp_idx;
  logic             rsp_err;
  logic [WIDTH-1:0] cam_key;
  logic [DEPTH-1:0] cam_match;
  logic             cam_wr_en;
  logic [IDXW-1:0]  cam_wr_addr;
  logic [WIDTH-1:0] cam_wr_data;
  logic [IDXW:0]    occupancy;
  logic             full;
  logic             empty;

  cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .rsp_err(rsp_err), .cam_key(cam_key), .cam_match(cam_match), .cam_wr_en(cam_wr_en),
    .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data), .occupancy(occupancy),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] LOOKUP = 2'b00, INSERT = 2'b01, DELETE = 2'b10, FLUSH = 2'b11;

  logic [WIDTH-1:0] cam_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [IDXW-1:0]  last_addr = '0;
  logic [WIDTH-1:0] last_data = '0;
  logic [5:0] exp_q [$];

  initial for (int i = 0; i < DEPTH; i++) cam_mem[i] = '0;

  always_comb begin
    cam_match = '0;
    for (int i = 0; i < DEPTH; i++) cam_match[i] = (cam_mem[i] == cam_key);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CAM model and write observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (cam_wr_en) begin
      cam_mem[cam_wr_addr] = cam_wr_data;
      wr_count++;
      last_addr = cam_wr_addr;
      last_data = cam_wr_data;
    end
  end

  // Scoreboard monitor: one pop per accepted response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("rsp_hit", 32'(rsp_hit), 32'(e[5]));
        chk("rsp_idx", 32'(rsp_idx), 32'(e[4:1]));
        chk("rsp_err", 32'(rsp_err), 32'(e[0]));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] key, input bit push,
                       input logic eh, input logic [3:0] ei, input logic ee);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) chk("issue_timeout", 32'd1, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    if (push) exp_q.push_back({eh, ei, ee});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(rsp_valid && rsp_ready) && t < 50) begin @(posedge clk); #1; t++; end
    if (!(rsp_valid && rsp_ready)) chk("rsp_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] key,
                     input logic eh, input logic [3:0] ei, input logic ee);
    issue(op, key, 1'b1, eh, ei, ee);
    wait_done();
  endtask

  initial begin
    int wc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_cam_key", 32'(cam_key), 32'd0);
    chk("rst_wr_en", 32'(cam_wr_en), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);

    // Key 0 insert with cycle-exact latency checks.
    issue(INSERT, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("search_no_rsp", 32'(rsp_valid), 32'd0);
    chk("search_no_wr", 32'(cam_wr_en), 32'd0);
    @(posedge clk); #1;
    chk("exec_wr_en", 32'(cam_wr_en), 32'd1);
    chk("exec_wr_addr", 32'(cam_wr_addr), 32'd0);
    chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid_n2", 32'(rsp_valid), 32'd1);
    chk("resp_wr_off", 32'(cam_wr_en), 32'd0);
    wait_done();
    chk("ins0_wr_count", 32'(wr_count), 32'd1);
    chk("ins0_occ", 32'(occupancy), 32'd1);
    cmd(LOOKUP, 8'h00, 1'b1, 4'd0, 1'b0);
    cmd(LOOKUP, 8'h55, 1'b0, 4'd0, 1'b0);

    // Lowest free slot after a delete.
    cmd(FLUSH, 8'h00, 1'b0, 4'd0, 1'b0);
    chk("flush1_occ", 32'(occupancy), 32'd0);
    cmd(INSERT, 8'h11, 1'b0, 4'd0, 1'b0);
    cmd(INSERT, 8'h22, 1'b0, 4'd1, 1'b0);
    cmd(INSERT, 8'h33, 1'b0, 4'd2, 1'b0);
    cmd(DELETE, 8'h22, 1'b1, 4'd1, 1'b0);
    chk("del_occ", 32'(occupancy), 32'd2);
    cmd(INSERT, 8'h44, 1'b0, 4'd1, 1'b0);
    chk("reuse_addr", 32'(last_addr), 32'd1);
    chk("reuse_data", 32'(last_data), 32'h44);
    chk("reuse_occ", 32'(occupancy), 32'd3);

    // Duplicate insert: hit, no write.
    wc = wr_count;
    cmd(INSERT, 8'h11, 1'b1, 4'd0, 1'b0);
    chk("dup_no_write", 32'(wr_count), 32'(wc));
    chk("dup_occ", 32'(occupancy), 32'd3);

    // Fill, overflow, delete miss, flush.
    for (int i = 0; i < 13; i++)
      cmd(INSERT, 8'h80 + 8'(i), 1'b0, 4'(3 + i), 1'b0);
    chk("fill_occ", 32'(occupancy), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    wc = wr_count;
    cmd(INSERT, 8'h99, 1'b0, 4'd0, 1'b1);
    chk("ovf_no_write", 32'(wr_count), 32'(wc));
    chk("ovf_full", 32'(full), 32'd1);
    cmd(LOOKUP, 8'h8C, 1'b1, 4'd15, 1'b0);
    cmd(DELETE, 8'h77, 1'b0, 4'd0, 1'b1);
    chk("delmiss_occ", 32'(occupancy), 32'd16);
    cmd(FLUSH, 8'h00, 1'b0, 4'd0, 1'b0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    cmd(LOOKUP, 8'h44, 1'b0, 4'd0, 1'b0);
    cmd(LOOKUP, 8'h85, 1'b0, 4'd0, 1'b0);

    // Backpressure on a hitting lookup.
    cmd(INSERT, 8'h5A, 1'b0, 4'd0, 1'b0);
    cmd(INSERT, 8'h6B, 1'b0, 4'd1, 1'b0);
    rsp_ready = 1'b0;
    issue(LOOKUP, 8'h6B, 1'b1, 1'b1, 4'd1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_fields", {27'd0, rsp_hit, rsp_idx}, {27'd0, 1'b1, 4'd1});
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("bp_pending", 32'(exp_q.size()), 32'd1);
    rsp_ready = 1'b1;
    wait_done();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(cmd_ready), 32'd1);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset during EXEC of an insert.
    wc = wr_count;
    issue(INSERT, 8'h66, 1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(cam_wr_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_occ", 32'(occupancy), 32'd0);
    chk("abort_no_write", 32'(wr_count), 32'(wc));
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(LOOKUP, 8'h66, 1'b0, 4'd0, 1'b0);
    cmd(LOOKUP, 8'h5A, 1'b0, 4'd0, 1'b0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Command sequencer for the CAM array. It accepts lookup/insert/delete/flush commands on a valid/ready port and drives the CAM search key and write port. It keeps the per-entry valid bitmap and occupancy count, so a stored key of 0 is never confused with an empty slot. It returns hit, index and error on a valid/ready response port, with lowest-index priority on multiple matches.

## Interface
- WIDTH, 8, key width in bits
- DEPTH, 16, number of CAM entries
- IDXW, $clog2(DEPTH), index width (derived)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 lookup, 01 insert, 10 delete, 11 flush
- cmd_key  in  WIDTH  key operand
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_hit  out  1  key found (or already present on insert)
- rsp_idx  out  IDXW  entry index
- rsp_err  out  1  insert when full, or delete miss
- cam_key  out  WIDTH  search key to CAM
- cam_match  in  DEPTH  raw CAM match vector (combinational from cam_key)
- cam_wr_en  out  1  CAM write strobe
- cam_wr_addr  out  IDXW  CAM write index
- cam_wr_data  out  WIDTH  CAM write data
- occupancy  out  IDXW+1  number of valid entries
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0

## Operation
- FSM states: IDLE, SEARCH, EXEC, RESP. The reset state is IDLE.
- IDLE: cmd_ready=1. When cmd_valid&&cmd_ready, latch op and key into op_q/key_q and go to SEARCH.
- SEARCH: cam_key=key_q. Register hit_vec <= cam_match & valid. Go to EXEC.
- EXEC: hit=|hit_vec. idx = lowest set bit of hit_vec. free = lowest clear bit of valid. Register the response fields, then go to RESP.
  - lookup: hit/idx as computed, err=0. On a miss, idx=0.
  - insert, hit: no write. rsp_hit=1, rsp_idx=existing index, err=0.
  - insert, miss, not full: cam_wr_en=1 for this cycle only, cam_wr_addr=free, cam_wr_data=key_q. Set valid[free], occupancy+1. rsp_hit=0, rsp_idx=free, err=0.
  - insert, miss, full: no write. hit=0, idx=0, err=1.
  - delete, hit: clear valid[idx], occupancy-1. hit=1, idx=matched index, err=0. The CAM is not written; the entry becomes invisible.
  - delete, miss: hit=0, idx=0, err=1.
  - flush: clear all valid bits, occupancy=0. hit=0, idx=0, err=0.
- RESP: rsp_valid=1. rsp_* fields stay stable until rsp_valid&&rsp_ready, then go to IDLE.
- cmd_ready is 0 in SEARCH, EXEC and RESP. Only one command is in flight at a time.
- cam_key always drives key_q, so it stays constant from SEARCH through RESP.
- Invariant: occupancy equals popcount(valid) at all times. full and empty are derived from occupancy.

## Timing
- Reset (rst_n low, any state): state=IDLE, valid=0, occupancy=0, key_q=0, rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_err=0, cam_wr_en=0, cam_wr_addr=0, cam_wr_data=0, cam_key=0, empty=1, full=0.
- Reset in the middle of an operation aborts the command. No response is issued and no write strobe is produced after rst_n falls. CAM contents are stale but masked by valid=0.
- Latency: command accepted at edge N. SEARCH during cycle N..N+1, EXEC during N+1..N+2. rsp_valid is high from edge N+2.
- cam_wr_en is high only during the EXEC cycle and is sampled by the CAM at edge N+2. The valid/occupancy update lands on the same edge.
- Minimum spacing between accepted commands is 4 cycles (RESP with rsp_ready=1, then IDLE).
- Backpressure: with rsp_ready held low, the controller stays in RESP indefinitely with stable outputs and cmd_ready=0.
- When several entries match, the lowest index wins. Free-slot selection also picks the lowest clear index.
- The result of a write or delete is visible to the next command's SEARCH.

## Test plan
- Reset, then insert 0x00 → rsp_hit=0, rsp_idx=0, err=0, cam_wr_en one cycle at addr 0, occupancy=1. Then lookup 0x00 → hit=1, idx=0. Then lookup 0x55 → hit=0, idx=0.
- Insert 0x11, 0x22, 0x33; delete 0x22; insert 0x44 → the 0x44 write goes to idx 1 (lowest free), occupancy=3.
- Insert 0x11 twice → second response hit=1, idx=0, err=0, no cam_wr_en, occupancy unchanged.
- Fill all 16 entries, then insert 0x99 → err=1, hit=0, full=1, no write. Delete 0x77 (absent) → err=1. Flush → occupancy=0, empty=1, and lookup of any prior key → hit=0.
- Hold rsp_ready=0 for 10 cycles after a lookup → rsp_valid stays 1 with stable fields and cmd_ready=0. Release → exactly one handshake, then IDLE.
- Assert rst_n=0 during EXEC of an insert → no rsp_valid, valid bitmap cleared, occupancy=0. After release, the next lookup of that key → hit=0.
